// File: rtl/dsp_ctrl_if.sv
// CPU-side register bus for dsp_ctrl.
// One-cycle request in, one-cycle ready/rdata back.
interface dsp_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/dsp_ctrl.sv
// Register front-end and sequencer for an external 8-lane DSP.
// Holds operands, launches one operation, captures results.
module dsp_ctrl #(
    parameter int TIMEOUT = 1023
) (
    input  logic            clk,
    input  logic            rst,
    dsp_ctrl_if.slave       bus,
    output logic            dsp_start,
    output logic [1:0]      dsp_operation,
    output logic [7:0][31:0] dsp_a,
    output logic [7:0][31:0] dsp_b,
    input  logic [7:0][31:0] dsp_result,
    input  logic            dsp_done,
    output logic            irq
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        CAPTURE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [7:0][31:0] a_q;
    logic [7:0][31:0] b_q;
    logic [7:0][31:0] res_q;
    logic [1:0]      op_q;
    logic            irq_en;
    logic            done_flag;
    logic            err_flag;
    logic            done_q;

    logic            wr;
    logic            busy;
    logic            ctrl_wr;
    logic            start_wr;
    logic            sts_wr;
    logic            done_rise;
    logic            tmo;
    logic            done_n;
    logic            err_n;
    logic [31:0]     rd_mux;

    assign wr        = bus.bus_req & bus.bus_we;
    assign busy      = (state != IDLE);
    assign ctrl_wr   = wr & (bus.bus_addr == 5'h18);
    assign start_wr  = ctrl_wr & bus.bus_wdata[0];
    assign sts_wr    = wr & (bus.bus_addr == 5'h19);
    assign done_rise = dsp_done & ~done_q;
    assign tmo       = (cnt == CW'(TIMEOUT - 1));

    assign dsp_a         = a_q;
    assign dsp_b         = b_q;
    assign dsp_operation = op_q;

    // Hardware sets are applied after the W1C so they win a collision.
    always_comb begin
        done_n = done_flag & ~(sts_wr & bus.bus_wdata[1]);
        err_n  = err_flag & ~(sts_wr & bus.bus_wdata[2]);
        if (state == CAPTURE)
            done_n = 1'b1;
        if (busy && start_wr)
            err_n = 1'b1;
        if (state == WAIT && !done_rise && tmo)
            err_n = 1'b1;
    end

    always_comb begin
        rd_mux = '0;
        case (bus.bus_addr[4:3])
            2'd0: rd_mux = a_q[bus.bus_addr[2:0]];
            2'd1: rd_mux = b_q[bus.bus_addr[2:0]];
            2'd2: rd_mux = res_q[bus.bus_addr[2:0]];
            default: begin
                case (bus.bus_addr[2:0])
                    3'd0: rd_mux = {29'd0, op_q, 1'b0};
                    3'd1: rd_mux = {29'd0, err_flag, done_flag, busy};
                    3'd2: rd_mux = {31'd0, irq_en};
                    default: rd_mux = '0;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            a_q           <= '0;
            b_q           <= '0;
            res_q         <= '0;
            op_q          <= 2'd0;
            irq_en        <= 1'b0;
            done_flag     <= 1'b0;
            err_flag      <= 1'b0;
            done_q        <= 1'b0;
            dsp_start     <= 1'b0;
            irq           <= 1'b0;
            bus.bus_ready <= 1'b0;
            bus.bus_rdata <= '0;
        end else begin
            bus.bus_ready <= bus.bus_req;
            bus.bus_rdata <= (bus.bus_req && !bus.bus_we) ? rd_mux : '0;
            done_q        <= dsp_done;
            done_flag     <= done_n;
            err_flag      <= err_n;
            irq           <= irq_en & (done_flag | err_flag);
            dsp_start     <= 1'b0;

            if (wr && bus.bus_addr == 5'h1A)
                irq_en <= bus.bus_wdata[0];

            // Operands and OP are frozen while an operation is in flight.
            if (wr && !busy) begin
                if (bus.bus_addr[4:3] == 2'd0)
                    a_q[bus.bus_addr[2:0]] <= bus.bus_wdata;
                if (bus.bus_addr[4:3] == 2'd1)
                    b_q[bus.bus_addr[2:0]] <= bus.bus_wdata;
                if (ctrl_wr)
                    op_q <= bus.bus_wdata[2:1];
            end

            case (state)
                IDLE: begin
                    if (start_wr) begin
                        state     <= LAUNCH;
                        dsp_start <= 1'b1;
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (done_rise)
                        state <= CAPTURE;
                    else if (tmo)
                        state <= IDLE;
                end
                CAPTURE: begin
                    res_q <= dsp_result;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
